// File: rtl/sevenseg_pkg.sv
// Shared types and constants for the BCD seven-segment display stage.
// Holds the converter state encoding, segment patterns and anode patterns.
package sevenseg_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_e;

    // Active-low {a,b,c,d,e,f,g}
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [6:0] SEG_DIGIT [0:9] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100
    };

    // Index = digit select; index 0 is the leftmost (thousands) digit.
    localparam logic [3:0] ANODE_SEL [0:3] = '{
        4'b0111, 4'b1011, 4'b1101, 4'b1110
    };

    function automatic logic [6:0] seg_of(input logic [3:0] nib);
        if (nib > 4'd9) begin
            return SEG_BLANK;
        end
        return SEG_DIGIT[nib];
    endfunction

    function automatic logic [3:0] add3(input logic [3:0] nib);
        return (nib >= 4'd5) ? nib + 4'd3 : nib;
    endfunction

endpackage

// File: rtl/sevenseg_bcd_display_bin2bcd.sv
// Sequential double-dabble binary-to-BCD converter, one bit per clock.
// Ports: clk, reset (sync, active-high), start, bin; busy, done, bcd[15:0].
module bin2bcd_seq
    import sevenseg_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] bin,
    output logic              busy,
    output logic              done,
    output logic [15:0]       bcd
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

    state_e            state_q, state_d;
    logic [DATA_W-1:0] bin_q, bin_d;
    logic [15:0]       bcd_q, bcd_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [15:0]       adj;

    always_comb begin
        adj = {add3(bcd_q[15:12]), add3(bcd_q[11:8]),
               add3(bcd_q[7:4]),   add3(bcd_q[3:0])};
    end

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    bin_d   = bin;
                    bcd_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                {bcd_d, bin_d} = {adj, bin_q} << 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            bin_q   <= '0;
            bcd_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
        end
    end

    // done is the commit strobe: high during the COMMIT cycle, so the
    // parent can register the result on the edge that ends busy.
    assign busy = (state_q != IDLE);
    assign done = (state_q == COMMIT);
    assign bcd  = bcd_q;

endmodule

// File: rtl/sevenseg_bcd_display.sv
// Latches a binary value, converts it to BCD and multiplexes it onto a
// 4-digit common-anode display.
// Ports: clk, reset (sync, active-high), value_valid, value[DATA_W];
//        busy, done, anode_n[3:0] (bit 3 = thousands), seg_n[6:0] {a..g}.
module sevenseg_bcd_display
    import sevenseg_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int REFRESH_W = 12,
    parameter bit BLANK_LZ  = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              value_valid,
    input  logic [DATA_W-1:0] value,
    output logic              busy,
    output logic              done,
    output logic [3:0]        anode_n,
    output logic [6:0]        seg_n
);

    logic        conv_busy;
    logic        conv_commit;
    logic [15:0] conv_bcd;

    logic [15:0]          disp_bcd_q, disp_bcd_d;
    logic                 done_q, done_d;
    logic [REFRESH_W-1:0] refresh_q, refresh_d;
    logic [3:0]           anode_n_q, anode_n_d;
    logic [6:0]           seg_n_q, seg_n_d;

    logic [1:0] sel;
    logic [3:0] nib;
    logic       lead_zero;

    bin2bcd_seq #(
        .DATA_W (DATA_W)
    ) u_conv (
        .clk   (clk),
        .reset (reset),
        .start (value_valid && !conv_busy),
        .bin   (value),
        .busy  (conv_busy),
        .done  (conv_commit),
        .bcd   (conv_bcd)
    );

    assign sel = refresh_q[REFRESH_W-1 -: 2];

    always_comb begin
        nib       = disp_bcd_q[3:0];
        lead_zero = 1'b0;
        unique case (sel)
            2'd0: begin
                nib       = disp_bcd_q[15:12];
                lead_zero = (disp_bcd_q[15:12] == '0);
            end
            2'd1: begin
                nib       = disp_bcd_q[11:8];
                lead_zero = (disp_bcd_q[15:8] == '0);
            end
            2'd2: begin
                nib       = disp_bcd_q[7:4];
                lead_zero = (disp_bcd_q[15:4] == '0);
            end
            2'd3: begin
                nib       = disp_bcd_q[3:0];
                lead_zero = 1'b0;
            end
            default: begin
                nib       = disp_bcd_q[3:0];
                lead_zero = 1'b0;
            end
        endcase
    end

    always_comb begin
        disp_bcd_d = conv_commit ? conv_bcd : disp_bcd_q;
        done_d     = conv_commit;
        refresh_d  = refresh_q + 1'b1;
        anode_n_d  = ANODE_SEL[sel];
        seg_n_d    = (BLANK_LZ && lead_zero) ? SEG_BLANK : seg_of(nib);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            disp_bcd_q <= '0;
            done_q     <= 1'b0;
            refresh_q  <= '0;
            anode_n_q  <= 4'b1111;
            seg_n_q    <= SEG_BLANK;
        end else begin
            disp_bcd_q <= disp_bcd_d;
            done_q     <= done_d;
            refresh_q  <= refresh_d;
            anode_n_q  <= anode_n_d;
            seg_n_q    <= seg_n_d;
        end
    end

    assign busy    = conv_busy;
    assign done    = done_q;
    assign anode_n = anode_n_q;
    assign seg_n   = seg_n_q;

endmodule
